// File: rtl/imem_arb.sv
// Instruction-RAM arbiter: fetch has priority; a starvation counter forces a loader slot; LdLock holds a burst.
// Grants are same-cycle combinational; read data and valids return one cycle after the grant; flush pulses after loader writes.
module imem_arb #(
   parameter int AW           = 6,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          FetchReq_IFM1,
   input  logic [AW-1:0] FetchAddr_IFM1,
   output logic          FetchGnt_IFM1,
   output logic          FetchStall_IFM1,
   output logic [DW-1:0] FetchData_IF,
   output logic          FetchValid_IF,
   input  logic          LdReq,
   input  logic          LdWe,
   input  logic          LdLock,
   input  logic [AW-1:0] LdAddr,
   input  logic [DW-1:0] LdWdata,
   output logic          LdGnt,
   output logic [DW-1:0] LdRdata,
   output logic          LdRvalid,
   output logic          ImemFlush,
   output logic          MemEn,
   output logic          MemWe,
   output logic [AW-1:0] MemAddr,
   output logic [DW-1:0] MemWdata,
   input  logic [DW-1:0] MemRdata
);

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_FORCE  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

   state_t        r_state;
   logic [3:0]    r_cnt;
   logic          r_rd;
   logic          r_owner;
   logic          r_flush;
   logic [DW-1:0] r_fdat;
   logic [DW-1:0] r_ldat;

   logic          w_fetch_gnt;
   logic          w_ld_gnt;
   logic          w_ld_rd;
   logic          w_ld_wr;
   logic          w_starve;
   logic [3:0]    w_cnt_inc;
   logic          w_fvld;
   logic          w_lvld;

   // Grants are gated by rst_n so the RAM port goes quiet the moment reset asserts.
   always_comb begin
      w_fetch_gnt = 1'b0;
      w_ld_gnt    = 1'b0;
      if (rst_n) begin
         case (r_state)
            ST_FETCH: begin
               w_fetch_gnt = FetchReq_IFM1;
               w_ld_gnt    = LdReq & ~FetchReq_IFM1;
            end
            ST_FORCE, ST_LOCKED: w_ld_gnt = LdReq;
            default: ;
         endcase
      end
   end

   assign w_ld_rd   = w_ld_gnt & ~LdWe;
   assign w_ld_wr   = w_ld_gnt & LdWe;
   assign w_starve  = LdReq & ~w_ld_gnt;
   assign w_cnt_inc = (r_cnt >= LIM) ? LIM : r_cnt + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_FETCH;
         r_cnt   <= 4'd0;
         r_rd    <= 1'b0;
         r_owner <= 1'b0;
         r_flush <= 1'b0;
         r_fdat  <= '0;
         r_ldat  <= '0;
      end else begin
         r_cnt <= w_starve ? w_cnt_inc : 4'd0;
         case (r_state)
            ST_FETCH: begin
               if (w_ld_gnt && LdLock)
                  r_state <= ST_LOCKED;
               else if (w_starve && (w_cnt_inc == LIM))
                  r_state <= ST_FORCE;
            end
            ST_FORCE:  r_state <= (w_ld_gnt && LdLock) ? ST_LOCKED : ST_FETCH;
            ST_LOCKED: if (!LdLock || !LdReq) r_state <= ST_FETCH;
            default:   r_state <= ST_FETCH;
         endcase
         r_rd    <= w_fetch_gnt | w_ld_rd;
         r_owner <= w_ld_gnt;
         r_flush <= w_ld_wr;
         // Capture the returning word so each side holds its last data once valid drops.
         if (w_fvld) r_fdat <= MemRdata;
         if (w_lvld) r_ldat <= MemRdata;
      end
   end

   assign w_fvld = r_rd & ~r_owner;
   assign w_lvld = r_rd & r_owner;

   assign FetchGnt_IFM1   = w_fetch_gnt;
   assign FetchStall_IFM1 = FetchReq_IFM1 & ~w_fetch_gnt;
   assign LdGnt           = w_ld_gnt;
   assign FetchValid_IF   = w_fvld;
   assign LdRvalid        = w_lvld;
   assign FetchData_IF    = w_fvld ? MemRdata : r_fdat;
   assign LdRdata         = w_lvld ? MemRdata : r_ldat;
   assign ImemFlush       = r_flush;

   assign MemEn    = w_fetch_gnt | w_ld_gnt;
   assign MemWe    = w_ld_wr;
   assign MemAddr  = w_ld_gnt ? LdAddr : FetchAddr_IFM1;
   assign MemWdata = w_ld_gnt ? LdWdata : '0;

endmodule

// File: tb/tb_imem_arb.sv
// Directed bench for imem_arb with a behavioural 64x32 synchronous RAM on the memory port.
module tb_imem_arb;

   logic        clk;
   logic        rst_n;
   logic        FetchReq_IFM1;
   logic [5:0]  FetchAddr_IFM1;
   logic        FetchGnt_IFM1;
   logic        FetchStall_IFM1;
   logic [31:0] FetchData_IF;
   logic        FetchValid_IF;
   logic        LdReq;
   logic        LdWe;
   logic        LdLock;
   logic [5:0]  LdAddr;
   logic [31:0] LdWdata;
   logic        LdGnt;
   logic [31:0] LdRdata;
   logic        LdRvalid;
   logic        ImemFlush;
   logic        MemEn;
   logic        MemWe;
   logic [5:0]  MemAddr;
   logic [31:0] MemWdata;
   logic [31:0] MemRdata;

   logic [31:0] ram [64];
   int n_chk;
   int n_bad;

   imem_arb #(.AW(6), .DW(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .FetchReq_IFM1(FetchReq_IFM1), .FetchAddr_IFM1(FetchAddr_IFM1),
      .FetchGnt_IFM1(FetchGnt_IFM1), .FetchStall_IFM1(FetchStall_IFM1),
      .FetchData_IF(FetchData_IF), .FetchValid_IF(FetchValid_IF),
      .LdReq(LdReq), .LdWe(LdWe), .LdLock(LdLock), .LdAddr(LdAddr), .LdWdata(LdWdata),
      .LdGnt(LdGnt), .LdRdata(LdRdata), .LdRvalid(LdRvalid), .ImemFlush(ImemFlush),
      .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
      .MemRdata(MemRdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (MemEn) begin
         if (MemWe) ram[MemAddr] <= MemWdata;
         else       MemRdata <= ram[MemAddr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drv(input logic fr, input logic [5:0] fa, input logic lr, input logic lw,
                      input logic ll, input logic [5:0] la, input logic [31:0] wd);
      FetchReq_IFM1  = fr;
      FetchAddr_IFM1 = fa;
      LdReq          = lr;
      LdWe           = lw;
      LdLock         = ll;
      LdAddr         = la;
      LdWdata        = wd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      n_chk = 0;
      n_bad = 0;
      for (int i = 0; i < 64; i++) ram[i] = 32'h1000_0000 + 32'(i);
      MemRdata = 32'h0;
      rst_n = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0);
      #3;
      check("rst_fvalid", {31'd0, FetchValid_IF}, 0);
      check("rst_lrvalid", {31'd0, LdRvalid}, 0);
      check("rst_flush", {31'd0, ImemFlush}, 0);
      check("rst_fdata", FetchData_IF, 0);
      check("rst_ldata", LdRdata, 0);
      check("rst_memen", {31'd0, MemEn}, 0);
      check("rst_cnt", {28'd0, dut.r_cnt}, 0);
      tick();
      rst_n = 1'b1;

      // fetch-only stream to addresses 0..2
      for (int i = 0; i < 3; i++) begin
         drv(1, 6'(i), 0, 0, 0, 0, 0);
         @(negedge clk);
         check("t1_fgnt", {31'd0, FetchGnt_IFM1}, 1);
         check("t1_stall", {31'd0, FetchStall_IFM1}, 0);
         check("t1_lgnt", {31'd0, LdGnt}, 0);
         check("t1_maddr", {26'd0, MemAddr}, 32'(i));
         tick();
         check("t1_fvalid", {31'd0, FetchValid_IF}, 1);
         check("t1_fdata", FetchData_IF, 32'h1000_0000 + 32'(i));
      end
      drv(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("idle_memen", {31'd0, MemEn}, 0);
      tick();
      check("idle_fvalid", {31'd0, FetchValid_IF}, 0);

      // loader write then same-address read
      drv(0, 0, 1, 1, 0, 6'd5, 32'hDEAD_BEEF);
      @(negedge clk);
      check("t2_wgnt", {31'd0, LdGnt}, 1);
      check("t2_memwe", {31'd0, MemWe}, 1);
      tick();
      check("t2_flush", {31'd0, ImemFlush}, 1);
      check("t2_lrv_w", {31'd0, LdRvalid}, 0);
      drv(0, 0, 1, 0, 0, 6'd5, 0);
      @(negedge clk);
      check("t2_rgnt", {31'd0, LdGnt}, 1);
      check("t2_memwe_r", {31'd0, MemWe}, 0);
      tick();
      check("t2_flush_off", {31'd0, ImemFlush}, 0);
      check("t2_lrv", {31'd0, LdRvalid}, 1);
      check("t2_ldata", LdRdata, 32'hDEAD_BEEF);
      check("t2_fhold", FetchData_IF, 32'h1000_0002);
      drv(0, 0, 0, 0, 0, 0, 0);
      tick();
      check("t2_lhold", LdRdata, 32'hDEAD_BEEF);

      // continuous fetch starves loader until the forced slot
      for (int k = 1; k <= 4; k++) begin
         drv(1, 6'd7, 1, 0, 0, 6'd3, 0);
         @(negedge clk);
         check("t3_fgnt", {31'd0, FetchGnt_IFM1}, 1);
         check("t3_lgnt", {31'd0, LdGnt}, 0);
         tick();
         check("t3_cnt", {28'd0, dut.r_cnt}, 32'(k));
         check("t3_fdata", FetchData_IF, 32'h1000_0007);
      end
      @(negedge clk);
      check("t3_force_lgnt", {31'd0, LdGnt}, 1);
      check("t3_force_fgnt", {31'd0, FetchGnt_IFM1}, 0);
      check("t3_force_stall", {31'd0, FetchStall_IFM1}, 1);
      tick();
      check("t3_lrv", {31'd0, LdRvalid}, 1);
      check("t3_ldata", LdRdata, 32'h1000_0003);
      check("t3_cnt0", {28'd0, dut.r_cnt}, 0);
      drv(1, 6'd8, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("t3_resume", {31'd0, FetchGnt_IFM1}, 1);
      tick();

      // locked 3-write burst while fetch waits
      drv(0, 0, 1, 1, 1, 6'd10, 32'hA0A0_000A);
      @(negedge clk);
      check("t4_a_lgnt", {31'd0, LdGnt}, 1);
      tick();
      check("t4_a_flush", {31'd0, ImemFlush}, 1);
      for (int b = 0; b < 2; b++) begin
         drv(1, 6'd9, 1, 1, 1, 6'(11 + b), 32'hB0B0_0000 + 32'(11 + b));
         @(negedge clk);
         check("t4_lgnt", {31'd0, LdGnt}, 1);
         check("t4_stall", {31'd0, FetchStall_IFM1}, 1);
         tick();
         check("t4_flush", {31'd0, ImemFlush}, 1);
      end
      drv(1, 6'd9, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("t4_exit_stall", {31'd0, FetchStall_IFM1}, 1);
      check("t4_exit_memen", {31'd0, MemEn}, 0);
      tick();
      check("t4_flush_off", {31'd0, ImemFlush}, 0);
      check("t4_cnt", {28'd0, dut.r_cnt}, 0);
      drv(1, 6'd10, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("t4_fgnt", {31'd0, FetchGnt_IFM1}, 1);
      tick();
      check("t4_fdata", FetchData_IF, 32'hA0A0_000A);

      // reset while LOCKED with a read in flight
      drv(0, 0, 1, 0, 1, 6'd11, 0);
      @(negedge clk);
      check("t5_lgnt", {31'd0, LdGnt}, 1);
      tick();
      check("t5_lrv", {31'd0, LdRvalid}, 1);
      check("t5_ldata", LdRdata, 32'hB0B0_000B);
      drv(1, 6'd1, 1, 0, 1, 6'd12, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5r_lrv", {31'd0, LdRvalid}, 0);
      check("t5r_ldata", LdRdata, 0);
      check("t5r_fvalid", {31'd0, FetchValid_IF}, 0);
      check("t5r_fdata", FetchData_IF, 0);
      check("t5r_flush", {31'd0, ImemFlush}, 0);
      check("t5r_lgnt", {31'd0, LdGnt}, 0);
      check("t5r_fgnt", {31'd0, FetchGnt_IFM1}, 0);
      check("t5r_memen", {31'd0, MemEn}, 0);
      LdLock = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("t6_fgnt", {31'd0, FetchGnt_IFM1}, 1);
      check("t6_lgnt", {31'd0, LdGnt}, 0);
      tick();
      check("t6_fvalid", {31'd0, FetchValid_IF}, 1);
      check("t6_fdata", FetchData_IF, 32'h1000_0001);
      check("t6_cnt", {28'd0, dut.r_cnt}, 1);
      drv(0, 0, 0, 0, 0, 0, 0);
      tick();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
